// File: rtl/keycode_event_decoder_if.sv
// Event stream from the keycode decoder to game logic: FIFO head plus occupancy.
// Handshake: the head moves on any rising clk where evt_valid && evt_ready; evt_valid never depends on evt_ready.
interface keycode_event_decoder_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          evt_valid;
  logic          evt_ready;
  logic          evt_press;
  logic [7:0]    evt_code;
  logic [CW-1:0] evt_count;

  modport master (output evt_valid, output evt_press, output evt_code, output evt_count,
                  input evt_ready);
  modport slave  (input evt_valid, input evt_press, input evt_code, input evt_count,
                  output evt_ready);
endinterface

// File: rtl/keycode_event_decoder.sv
// Turns changes in the six HID keycode slots into press/release events, filtered for
// stability and HID error reports, buffered in a first-word-fall-through FIFO.
module keycode_event_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int DEPTH         = 8
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [7:0]             keycode1_in,
  input  logic [7:0]             keycode2_in,
  input  logic [7:0]             keycode3_in,
  input  logic [7:0]             keycode4_in,
  input  logic [7:0]             keycode5_in,
  input  logic [7:0]             keycode6_in,
  keycode_event_decoder_if.master evt,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [4:0]             held,
  output logic                   busy,
  output logic [2:0]             dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(STABLE_CYCLES + 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SCAN_REL, S_SCAN_PRS, S_COMMIT} state_t;

  state_t          state, state_nx;
  logic [5:0][7:0] live, prev, cand;
  logic [NW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      cur_prev, cur_cand;
  logic            prev_dup, cand_dup, rel_hit, prs_hit, cand_err;
  logic            push;
  logic [8:0]      push_data;

  assign live = {keycode6_in, keycode5_in, keycode4_in, keycode3_in, keycode2_in, keycode1_in};

  function automatic logic has_code(input logic [5:0][7:0] snap, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) if (snap[i] == code) hit = 1'b1;
    return hit;
  endfunction

  // A release needs the code absent from the new snapshot; duplicates in earlier slots already reported it.
  always_comb begin
    cur_prev = prev[idx];
    cur_cand = cand[idx];
    prev_dup = 1'b0;
    cand_dup = 1'b0;
    cand_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(idx) && prev[i] == cur_prev) prev_dup = 1'b1;
      if (i < int'(idx) && cand[i] == cur_cand) cand_dup = 1'b1;
      if (cand[i] >= 8'h01 && cand[i] <= 8'h03) cand_err = 1'b1;
    end
    rel_hit = (cur_prev != 8'h00) && !has_code(cand, cur_prev) && !prev_dup;
    prs_hit = (cur_cand != 8'h00) && !has_code(prev, cur_cand) && !cand_dup;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (live != prev) state_nx = S_SETTLE;
      S_SETTLE:   if (live == cand && cnt == CNT_LAST) state_nx = cand_err ? S_IDLE : S_SCAN_REL;
      S_SCAN_REL: if (idx == 3'd5) state_nx = S_SCAN_PRS;
      S_SCAN_PRS: if (idx == 3'd5) state_nx = S_COMMIT;
      S_COMMIT:   state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    dbg_state = state;
    push      = (state == S_SCAN_REL && rel_hit) || (state == S_SCAN_PRS && prs_hit);
    push_data = (state == S_SCAN_REL) ? {1'b0, cur_prev} : {1'b1, cur_cand};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev <= '0;
      cand <= '0;
      cnt  <= '0;
      idx  <= '0;
      held <= '0;
    end else begin
      case (state)
        S_IDLE: if (live != prev) begin
          cand <= live;
          cnt  <= '0;
        end
        S_SETTLE: begin
          idx <= '0;
          if (live != cand) begin
            cand <= live;
            cnt  <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SCAN_REL: idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        S_SCAN_PRS: idx <= idx + 3'd1;
        S_COMMIT: begin
          prev <= cand;
          held <= {has_code(cand, 8'h2C), has_code(cand, 8'h07), has_code(cand, 8'h16),
                   has_code(cand, 8'h04), has_code(cand, 8'h1A)};
        end
        default: ;
      endcase
    end
  end

  // Event FIFO; a push into a full FIFO still lands when the head pops in the same cycle.
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, push_ok, drop;

  assign pop     = (count != '0) && evt.evt_ready;
  assign push_ok = push && ((count < CW'(DEPTH)) || pop);
  assign drop    = push && !push_ok;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    evt.evt_valid = (count != '0);
    evt.evt_count = count;
    evt.evt_press = evt.evt_valid ? mem[rd_ptr][8]   : 1'b0;
    evt.evt_code  = evt.evt_valid ? mem[rd_ptr][7:0] : 8'h00;
  end
endmodule

// File: tb/tb_keycode_event_decoder.sv
// Directed bench for keycode_event_decoder: stability filter, event order, FIFO overflow,
// HID error filtering, duplicate suppression and asynchronous reset.
module tb_keycode_event_decoder;
  localparam int STABLE = 16;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] k1, k2, k3, k4, k5, k6;
  logic       overflow, ovf_clr;
  logic [4:0] held;
  logic       busy;
  logic [2:0] dbg_state;
  int         n_cmp  = 0;
  int         n_fail = 0;

  keycode_event_decoder_if #(.DEPTH(DEPTH)) evt_bus ();

  keycode_event_decoder #(.STABLE_CYCLES(STABLE), .DEPTH(DEPTH)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .keycode1_in(k1), .keycode2_in(k2), .keycode3_in(k3),
    .keycode4_in(k4), .keycode5_in(k5), .keycode6_in(k6),
    .evt(evt_bus.master),
    .overflow(overflow), .ovf_clr(ovf_clr), .held(held), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_keys(input logic [7:0] a, b, c, d, e, f);
    k1 = a; k2 = b; k3 = c; k4 = d; k5 = e; k6 = f;
  endtask

  // Waits for one decoder pass to start (if not already running) and to finish.
  task automatic wait_pass();
    int n = 0;
    while (!busy && n < 100) begin cycle(); n++; end
    if (!busy) begin
      n_cmp++; n_fail++;
      $display("FAIL pass_start: busy=%0b after %0d cycles, required 1", busy, n);
    end
    n = 0;
    while (busy && n < 200) begin cycle(); n++; end
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL pass_end: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic pop_event(output logic ok, output logic p, output logic [7:0] c);
    ok = evt_bus.evt_valid;
    p  = evt_bus.evt_press;
    c  = evt_bus.evt_code;
    evt_bus.evt_ready = 1'b1;
    cycle();
    evt_bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    evt_bus.evt_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({evt_bus.evt_valid, evt_bus.evt_press, evt_bus.evt_code, evt_bus.evt_count,
         overflow, held, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b press=%0b code=%h count=%0d ovf=%0b held=%b busy=%0b, required all 0",
               evt_bus.evt_valid, evt_bus.evt_press, evt_bus.evt_code, evt_bus.evt_count,
               overflow, held, busy);
    end
    rst_n = 1'b1;
    repeat (5) cycle();
    n_cmp++;
    if (busy !== 1'b0 || evt_bus.evt_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_quiet: busy=%0b count=%0d, required 0/0", busy, evt_bus.evt_count);
    end
  endtask

  task automatic test_press_release();
    int first_valid = 0;
    int busy_cyc = 0;
    logic ok, p;
    logic [7:0] c;
    set_keys(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      cycle();
      if (busy) busy_cyc++;
      if (evt_bus.evt_valid && first_valid == 0) first_valid = cyc;
    end
    n_cmp++;
    if (first_valid !== STABLE + 8) begin
      n_fail++;
      $display("FAIL press_latency: first valid at cycle %0d, required %0d", first_valid, STABLE + 8);
    end
    n_cmp++;
    if (busy_cyc !== STABLE + 13) begin
      n_fail++;
      $display("FAIL pass_length: busy %0d cycles, required %0d", busy_cyc, STABLE + 13);
    end
    n_cmp++;
    if (evt_bus.evt_count !== 3'd1 || evt_bus.evt_press !== 1'b1 || evt_bus.evt_code !== 8'h04) begin
      n_fail++;
      $display("FAIL press_event: count=%0d press=%0b code=%h, required 1/1/04",
               evt_bus.evt_count, evt_bus.evt_press, evt_bus.evt_code);
    end
    n_cmp++;
    if (held !== 5'b00010) begin
      n_fail++;
      $display("FAIL press_held: held=%b, required 00010", held);
    end
    pop_event(ok, p, c);
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd1 || evt_bus.evt_press !== 1'b0 || evt_bus.evt_code !== 8'h04) begin
      n_fail++;
      $display("FAIL release_event: count=%0d press=%0b code=%h, required 1/0/04",
               evt_bus.evt_count, evt_bus.evt_press, evt_bus.evt_code);
    end
    n_cmp++;
    if (held !== 5'b00000) begin
      n_fail++;
      $display("FAIL release_held: held=%b, required 00000", held);
    end
    pop_event(ok, p, c);
  endtask

  task automatic test_glitch();
    set_keys(8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (10) cycle();
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd0 || held !== 5'b00000) begin
      n_fail++;
      $display("FAIL glitch_filtered: count=%0d held=%b, required 0/00000", evt_bus.evt_count, held);
    end
  endtask

  task automatic test_release_press_order();
    logic ok, p;
    logic [7:0] c;
    set_keys(8'h04, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b1 || c !== 8'h04) begin
      n_fail++;
      $display("FAIL order_setup0: valid=%0b press=%0b code=%h, required 1/1/04", ok, p, c);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b1 || c !== 8'h1A) begin
      n_fail++;
      $display("FAIL order_setup1: valid=%0b press=%0b code=%h, required 1/1/1a", ok, p, c);
    end
    set_keys(8'h1A, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd2) begin
      n_fail++;
      $display("FAIL order_count: count=%0d, required 2", evt_bus.evt_count);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b0 || c !== 8'h04) begin
      n_fail++;
      $display("FAIL order_first: valid=%0b press=%0b code=%h, required 1/0/04", ok, p, c);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b1 || c !== 8'h16) begin
      n_fail++;
      $display("FAIL order_second: valid=%0b press=%0b code=%h, required 1/1/16", ok, p, c);
    end
    n_cmp++;
    if (held !== 5'b00101) begin
      n_fail++;
      $display("FAIL order_held: held=%b, required 00101", held);
    end
  endtask

  task automatic test_rollover_dup();
    logic ok, p;
    logic [7:0] c;
    set_keys(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    repeat (80) cycle();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd0 || held !== 5'b00101) begin
      n_fail++;
      $display("FAIL rollover_ignored: count=%0d held=%b, required 0/00101", evt_bus.evt_count, held);
    end
    set_keys(8'h00, 8'h00, 8'h2C, 8'h00, 8'h2C, 8'h00);
    wait_pass();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd3) begin
      n_fail++;
      $display("FAIL dup_count: count=%0d, required 3", evt_bus.evt_count);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b0 || c !== 8'h1A) begin
      n_fail++;
      $display("FAIL dup_rel_w: valid=%0b press=%0b code=%h, required 1/0/1a", ok, p, c);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b0 || c !== 8'h16) begin
      n_fail++;
      $display("FAIL dup_rel_s: valid=%0b press=%0b code=%h, required 1/0/16", ok, p, c);
    end
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b1 || c !== 8'h2C) begin
      n_fail++;
      $display("FAIL dup_press: valid=%0b press=%0b code=%h, required 1/1/2c", ok, p, c);
    end
    n_cmp++;
    if (held !== 5'b10000 || evt_bus.evt_count !== 3'd0) begin
      n_fail++;
      $display("FAIL dup_held: held=%b count=%0d, required 10000/0", held, evt_bus.evt_count);
    end
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    pop_event(ok, p, c);
    n_cmp++;
    if (!ok || p !== 1'b0 || c !== 8'h2C) begin
      n_fail++;
      $display("FAIL dup_release: valid=%0b press=%0b code=%h, required 1/0/2c", ok, p, c);
    end
  endtask

  task automatic test_overflow();
    logic ok, p;
    logic [7:0] c;
    logic [8:0] exp_q[$];
    int n = 0;
    set_keys(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    wait_pass();
    n_cmp++;
    if (evt_bus.evt_count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_fill: count=%0d overflow=%0b, required 4/1", evt_bus.evt_count, overflow);
    end
    n_cmp++;
    if (held !== 5'b01010 || evt_bus.evt_code !== 8'h04) begin
      n_fail++;
      $display("FAIL ovf_held_head: held=%b head=%h, required 01010/04", held, evt_bus.evt_code);
    end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%0b, required 0", overflow);
    end
    // Releasing all keys pushes 0x04's release in the first scan cycle; pop exactly then.
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    while (dbg_state !== 3'd2 && n < 100) begin cycle(); n++; end
    evt_bus.evt_ready = 1'b1;
    cycle();
    evt_bus.evt_ready = 1'b0;
    n_cmp++;
    if (evt_bus.evt_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d, required 4", evt_bus.evt_count);
    end
    wait_pass();
    n_cmp++;
    if (overflow !== 1'b1 || evt_bus.evt_count !== 3'd4 || held !== 5'b00000) begin
      n_fail++;
      $display("FAIL ovf_again: overflow=%0b count=%0d held=%b, required 1/4/00000",
               overflow, evt_bus.evt_count, held);
    end
    exp_q = '{{1'b1, 8'h05}, {1'b1, 8'h06}, {1'b1, 8'h07}, {1'b0, 8'h04}};
    while (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      pop_event(ok, p, c);
      n_cmp++;
      if (!ok || {p, c} !== e) begin
        n_fail++;
        $display("FAIL ovf_drain: valid=%0b got=%h, required 1/%h", ok, {p, c}, e);
      end
    end
    n_cmp++;
    if (evt_bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty: valid=%0b, required 0", evt_bus.evt_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    set_keys(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_pass();
    set_keys(8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    while (dbg_state !== 3'd3 && n < 100) begin cycle(); n++; end
    n_cmp++;
    if (dbg_state !== 3'd3 || held !== 5'b00010 || evt_bus.evt_count !== 3'd2) begin
      n_fail++;
      $display("FAIL midscan_setup: state=%0d held=%b count=%0d, required 3/00010/2",
               dbg_state, held, evt_bus.evt_count);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (evt_bus.evt_valid !== 1'b0 || evt_bus.evt_count !== 3'd0 || held !== 5'b00000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: valid=%0b count=%0d held=%b busy=%0b, required 0/0/00000/0",
               evt_bus.evt_valid, evt_bus.evt_count, held, busy);
    end
    set_keys(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle();
    n_cmp++;
    if (busy !== 1'b0 || evt_bus.evt_count !== 3'd0) begin
      n_fail++;
      $display("FAIL midscan_after: busy=%0b count=%0d, required 0/0", busy, evt_bus.evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_release_press_order();
    test_rollover_dup();
    test_overflow();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
